// File: rtl/dmem_seq_pkg.sv
// Shared types and helpers for the byte-sequenced data-memory port.
// Beats are numbered from the most significant byte (big-endian).
package dmem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_TAIL = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic PORT_P = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam int   BEATS  = 4;

    // Beat 0 carries bits 31:24, beat 3 carries bits 7:0.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] beat);
        return word[8*(BEATS-1-int'(beat)) +: 8];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention it grants the port not granted last.
// last_grant only moves when the caller accepts a grant via advance.
module rr_arb2
    import dmem_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant_reg;

    always_comb begin
        gnt_valid = |req;
        if (req[PORT_P] && req[PORT_D]) begin
            gnt_id = ~last_grant_reg;
        end else if (req[PORT_D]) begin
            gnt_id = PORT_D;
        end else begin
            gnt_id = PORT_P;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_reg <= PORT_D;
        end else if (advance && gnt_valid) begin
            last_grant_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/dmem_port_sequencer.sv
// Shares a byte-wide big-endian data memory between the pipeline (P) and DMA (D)
// word ports, sequencing each 32-bit access as four byte beats.
module dmem_port_sequencer
    import dmem_seq_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_wdata,
    output logic [31:0]       p_rdata,
    output logic              p_ack,
    output logic              p_err,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            state_reg, state_next;
    logic [1:0]        beat_reg, beat_next;
    logic              port_reg;
    logic              we_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       wdata_reg;
    logic [23:0]       asm_reg;
    logic              rd_pend_reg;

    logic              arb_advance;
    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_bad;

    logic [1:0]        ack_vec;
    logic [1:0]        err_vec;
    logic [1:0][31:0]  rdata_vec;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({d_req, p_req}),
        .advance   (arb_advance),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_we    = (gnt_id == PORT_D) ? d_we    : p_we;
    assign sel_addr  = (gnt_id == PORT_D) ? d_addr  : p_addr;
    assign sel_wdata = (gnt_id == PORT_D) ? d_wdata : p_wdata;
    // Full 32-bit compare so high address bits cannot alias into the memory.
    assign sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > 32'(DEPTH - BEATS));

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        arb_advance = 1'b0;
        mem_addr    = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        case (state_reg)
            IDLE: begin
                arb_advance = 1'b1;
                if (gnt_valid) begin
                    beat_next  = 2'd0;
                    state_next = sel_bad ? ACK : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr  = base_reg + ADDR_W'(beat_reg);
                beat_next = beat_reg + 2'd1;
                if (we_reg) begin
                    mem_we    = 1'b1;
                    mem_wdata = byte_lane(wdata_reg, beat_reg);
                end else begin
                    mem_re = 1'b1;
                end
                if (beat_reg == 2'(BEATS - 1)) begin
                    state_next = we_reg ? ACK : RD_TAIL;
                end
            end
            RD_TAIL: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            beat_reg    <= 2'd0;
            port_reg    <= PORT_P;
            we_reg      <= 1'b0;
            err_reg     <= 1'b0;
            base_reg    <= '0;
            wdata_reg   <= 32'h0;
            asm_reg     <= 24'h0;
            rd_pend_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            beat_reg    <= beat_next;
            rd_pend_reg <= mem_re;
            if (rd_pend_reg) begin
                asm_reg <= {asm_reg[15:0], mem_rdata};
            end
            if (state_reg == IDLE && gnt_valid) begin
                port_reg  <= gnt_id;
                we_reg    <= sel_we;
                err_reg   <= sel_bad;
                base_reg  <= sel_addr[ADDR_W-1:0];
                wdata_reg <= sel_wdata;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] rdata_reg;

            // The last byte is still on mem_rdata in RD_TAIL, so it is merged directly.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rdata_reg <= 32'h0;
                end else if (state_reg == RD_TAIL && port_reg == 1'(gi)) begin
                    rdata_reg <= {asm_reg, mem_rdata};
                end
            end

            assign rdata_vec[gi] = rdata_reg;
            assign ack_vec[gi]   = (state_reg == ACK) && (port_reg == 1'(gi));
            assign err_vec[gi]   = ack_vec[gi] && err_reg;
        end
    endgenerate

    assign p_ack   = ack_vec[PORT_P];
    assign d_ack   = ack_vec[PORT_D];
    assign p_err   = err_vec[PORT_P];
    assign d_err   = err_vec[PORT_D];
    assign p_rdata = rdata_vec[PORT_P];
    assign d_rdata = rdata_vec[PORT_D];
    assign p_stall = p_req & ~p_ack;

endmodule
